// File: rtl/tdc_bist_pkg.sv
// Shared types and helpers for the TDC self-test stimulus generator.
// Holds the sequencer state set, the phase-ring reset pattern and the min-one length rule.
package tdc_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_GAP,
    ST_GATE,
    ST_TAIL,
    ST_DONE
  } state_e;

  localparam int PHASE_MAX = 256;

  // Upper half of the ring set, lower half clear; callers truncate to their width.
  function automatic logic [PHASE_MAX-1:0] phase_init(input int nphase);
    logic [PHASE_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < PHASE_MAX; i++) begin
      if (i >= nphase / 2 && i < nphase) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] l_len(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/tdc_phase_ring.sv
// Free-running DLL emulation ring: rotates right one bit per clk_i, 50% duty, period NPHASE.
// Output is the register itself; no handshake, it never stalls.
module tdc_phase_ring
  import tdc_bist_pkg::*;
#(
  parameter int NPHASE = 32
) (
  input  logic              clk_i,
  input  logic              rst,
  output logic [NPHASE-1:0] dll_phase
);

  localparam logic [NPHASE-1:0] RING_INIT = NPHASE'(phase_init(NPHASE));

  logic [NPHASE-1:0] ring_q;
  logic [NPHASE-1:0] ring_d;

  always_comb begin
    ring_d = {ring_q[0], ring_q[NPHASE-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) ring_q <= RING_INIT;
    else      ring_q <= ring_d;
  end

  assign dll_phase = ring_q;

endmodule

// File: rtl/tdc_bist_gen.sv
// TDC self-test stimulus: start pulse then npulse gap/gate/tail trains with rotating SPAD pattern.
// Outputs registered, start/busy one cycle after en is seen in IDLE; en low aborts outside DONE.
module tdc_bist_gen
  import tdc_bist_pkg::*;
#(
  parameter int NPHASE = 32,
  parameter int NSPAD  = 16,
  parameter int CNTW   = 16,
  parameter int PCNTW  = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              en,
  input  logic [CNTW-1:0]   cfg_start_len,
  input  logic [CNTW-1:0]   cfg_gap,
  input  logic [CNTW-1:0]   cfg_gate_len,
  input  logic [CNTW-1:0]   cfg_tail_len,
  input  logic [PCNTW-1:0]  cfg_npulse,
  input  logic [NSPAD-1:0]  cfg_spaden,
  input  logic              cfg_rotate,
  output logic [NPHASE-1:0] dll_phase,
  output logic              tdc_start,
  output logic              tdc_trigger,
  output logic              tdc_tgate,
  output logic [NSPAD-1:0]  tdc_spaden,
  output logic              busy,
  output logic              done,
  output logic [PCNTW-1:0]  pulse_idx
);

  function automatic logic [CNTW-1:0] load_of(input logic [CNTW-1:0] x);
    return CNTW'(l_len(32'(x)) - 32'd1);
  endfunction

  tdc_phase_ring #(.NPHASE(NPHASE)) u_ring (
    .clk_i     (clk_i),
    .rst       (rst),
    .dll_phase (dll_phase)
  );

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [PCNTW-1:0]  pidx_q, pidx_d;
  logic [NSPAD-1:0]  pat_q, pat_d;
  logic [CNTW-1:0]   gap_q, gap_d;
  logic [CNTW-1:0]   gate_q, gate_d;
  logic [CNTW-1:0]   tail_q, tail_d;
  logic [PCNTW-1:0]  npulse_q, npulse_d;
  logic              rotate_q, rotate_d;
  logic              start_q, start_d;
  logic              trig_q, trig_d;
  logic              tgate_q, tgate_d;
  logic [NSPAD-1:0]  spaden_q, spaden_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pidx_d   = pidx_q;
    pat_d    = pat_q;
    gap_d    = gap_q;
    gate_d   = gate_q;
    tail_d   = tail_q;
    npulse_d = npulse_q;
    rotate_d = rotate_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_START;
          cnt_d    = load_of(cfg_start_len);
          pidx_d   = '0;
          pat_d    = cfg_spaden;
          gap_d    = cfg_gap;
          gate_d   = cfg_gate_len;
          tail_d   = cfg_tail_len;
          npulse_d = cfg_npulse;
          rotate_d = cfg_rotate;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        pidx_d  = '0;
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pidx_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            ST_START: begin
              if (npulse_q != '0) begin
                state_d = ST_GAP;
                cnt_d   = load_of(gap_q);
              end else begin
                state_d = ST_DONE;
              end
            end
            ST_GAP: begin
              state_d = ST_GATE;
              cnt_d   = load_of(gate_q);
            end
            ST_GATE: begin
              state_d = ST_TAIL;
              cnt_d   = load_of(tail_q);
            end
            ST_TAIL: begin
              pidx_d = pidx_q + 1'b1;
              if (pidx_d == npulse_q) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_GAP;
                cnt_d   = load_of(gap_q);
                if (rotate_q) pat_d = {pat_q[NSPAD-2:0], pat_q[NSPAD-1]};
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase

    // Outputs follow the state being entered so they change on the entry edge.
    start_d  = (state_d == ST_START);
    tgate_d  = (state_d == ST_GATE);
    trig_d   = (state_d == ST_GATE) || (state_d == ST_TAIL);
    spaden_d = trig_d ? pat_d : '0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pidx_q   <= '0;
      pat_q    <= '0;
      gap_q    <= '0;
      gate_q   <= '0;
      tail_q   <= '0;
      npulse_q <= '0;
      rotate_q <= 1'b0;
      start_q  <= 1'b0;
      trig_q   <= 1'b0;
      tgate_q  <= 1'b0;
      spaden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pidx_q   <= pidx_d;
      pat_q    <= pat_d;
      gap_q    <= gap_d;
      gate_q   <= gate_d;
      tail_q   <= tail_d;
      npulse_q <= npulse_d;
      rotate_q <= rotate_d;
      start_q  <= start_d;
      trig_q   <= trig_d;
      tgate_q  <= tgate_d;
      spaden_q <= spaden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tdc_start   = start_q;
  assign tdc_trigger = trig_q;
  assign tdc_tgate   = tgate_q;
  assign tdc_spaden  = spaden_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_idx   = pidx_q;

endmodule

// File: tb/tb_tdc_bist_gen.sv
// Bench for tdc_bist_gen: per-cycle comparison against a sequence-list model plus directed literal checks.
module tb_tdc_bist_gen;

  localparam int NPHASE = 8;
  localparam int NSPAD  = 16;
  localparam int CNTW   = 16;
  localparam int PCNTW  = 8;
  localparam logic [NPHASE-1:0] RING0 = 8'hF0;

  logic              clk_i = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [CNTW-1:0]   cfg_start_len = '0;
  logic [CNTW-1:0]   cfg_gap = '0;
  logic [CNTW-1:0]   cfg_gate_len = '0;
  logic [CNTW-1:0]   cfg_tail_len = '0;
  logic [PCNTW-1:0]  cfg_npulse = '0;
  logic [NSPAD-1:0]  cfg_spaden = '0;
  logic              cfg_rotate = 1'b0;
  logic [NPHASE-1:0] dll_phase;
  logic              tdc_start, tdc_trigger, tdc_tgate, busy, done;
  logic [NSPAD-1:0]  tdc_spaden;
  logic [PCNTW-1:0]  pulse_idx;

  always #5 clk_i = ~clk_i;

  tdc_bist_gen #(.NPHASE(NPHASE), .NSPAD(NSPAD), .CNTW(CNTW), .PCNTW(PCNTW)) dut (
    .clk_i(clk_i), .rst(rst), .en(en),
    .cfg_start_len(cfg_start_len), .cfg_gap(cfg_gap), .cfg_gate_len(cfg_gate_len),
    .cfg_tail_len(cfg_tail_len), .cfg_npulse(cfg_npulse), .cfg_spaden(cfg_spaden),
    .cfg_rotate(cfg_rotate), .dll_phase(dll_phase), .tdc_start(tdc_start),
    .tdc_trigger(tdc_trigger), .tdc_tgate(tdc_tgate), .tdc_spaden(tdc_spaden),
    .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one expected output vector per cycle, the whole sequence expanded at start.
  typedef struct packed {
    logic             st;
    logic             tr;
    logic             tg;
    logic [NSPAD-1:0] sp;
    logic             bz;
    logic             dn;
    logic [PCNTW-1:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  int   ring_t = 0;

  function automatic int len_of(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic build_seq();
    exp_t v;
    logic [NSPAD-1:0] p;
    p = cfg_spaden;
    for (int i = 0; i < len_of(int'(cfg_start_len)); i++) begin
      v = '0; v.st = 1'b1; v.bz = 1'b1; q.push_back(v);
    end
    for (int k = 0; k < int'(cfg_npulse); k++) begin
      for (int i = 0; i < len_of(int'(cfg_gap)); i++) begin
        v = '0; v.bz = 1'b1; v.idx = PCNTW'(k); q.push_back(v);
      end
      for (int i = 0; i < len_of(int'(cfg_gate_len)); i++) begin
        v = '0; v.bz = 1'b1; v.tr = 1'b1; v.tg = 1'b1; v.sp = p; v.idx = PCNTW'(k); q.push_back(v);
      end
      for (int i = 0; i < len_of(int'(cfg_tail_len)); i++) begin
        v = '0; v.bz = 1'b1; v.tr = 1'b1; v.sp = p; v.idx = PCNTW'(k); q.push_back(v);
      end
      if (cfg_rotate) p = (p << 1) | (p >> (NSPAD - 1));
    end
    v = '0; v.bz = 1'b1; v.dn = 1'b1; v.idx = cfg_npulse; q.push_back(v);
    v = '0; q.push_back(v);
  endtask

  initial begin
    exp_t got;
    logic [2*NPHASE-1:0] dbl;
    logic [NPHASE-1:0] exp_ring;
    forever begin
      @(posedge clk_i or negedge rst);
      if (!rst) begin
        q.delete(); cur = '0; ring_t = 0;
      end else begin
        ring_t++;
        if (cur.bz && !cur.dn && !en) begin
          q.delete(); cur = '0;
        end else if (q.size() == 0) begin
          if (en) begin build_seq(); cur = q.pop_front(); end
          else cur = '0;
        end else begin
          cur = q.pop_front();
        end
      end
      #1;
      got.st = tdc_start; got.tr = tdc_trigger; got.tg = tdc_tgate; got.sp = tdc_spaden;
      got.bz = busy; got.dn = done; got.idx = pulse_idx;
      checks++;
      if (got !== cur) begin
        errors++;
        $display("FAIL outputs t=%0t got st=%b tr=%b tg=%b sp=%h busy=%b done=%b idx=%0d expected st=%b tr=%b tg=%b sp=%h busy=%b done=%b idx=%0d",
                 $time, got.st, got.tr, got.tg, got.sp, got.bz, got.dn, got.idx,
                 cur.st, cur.tr, cur.tg, cur.sp, cur.bz, cur.dn, cur.idx);
      end
      dbl = {RING0, RING0} >> (ring_t % NPHASE);
      exp_ring = dbl[NPHASE-1:0];
      checks++;
      if (dll_phase !== exp_ring) begin
        errors++;
        $display("FAIL ring t=%0t got=%h expected=%h", $time, dll_phase, exp_ring);
      end
    end
  end

  int n_start, n_trig, n_tgate, done_cyc;
  logic [NSPAD-1:0] sp_seen[$];

  task automatic set_cfg(input int s, input int g, input int gt, input int t, input int np,
                         input logic [NSPAD-1:0] sp, input logic rot);
    cfg_start_len = CNTW'(s); cfg_gap = CNTW'(g); cfg_gate_len = CNTW'(gt);
    cfg_tail_len = CNTW'(t); cfg_npulse = PCNTW'(np); cfg_spaden = sp; cfg_rotate = rot;
  endtask

  task automatic run_seq();
    int c;
    logic prev_trig;
    n_start = 0; n_trig = 0; n_tgate = 0; done_cyc = -1; sp_seen.delete();
    prev_trig = 1'b0; c = 0;
    @(negedge clk_i); en = 1'b1;
    do begin
      @(posedge clk_i); #1; c++;
      if (c == 1) begin
        chk("first_start", {31'd0, tdc_start}, 32'd1);
        chk("first_busy", {31'd0, busy}, 32'd1);
      end
      if (tdc_start) n_start++;
      if (tdc_trigger) n_trig++;
      if (tdc_tgate) n_tgate++;
      if (tdc_trigger && !prev_trig) sp_seen.push_back(tdc_spaden);
      prev_trig = tdc_trigger;
      // Scramble live config; the running sequence must not see it.
      cfg_gap = CNTW'($urandom_range(0, 9)); cfg_spaden = NSPAD'($urandom);
    end while (!done && c < 300);
    if (done) done_cyc = c;
    chk("seq_timeout", {31'd0, done}, 32'd1);
    @(negedge clk_i); en = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [NPHASE-1:0] ring_lits [8];
    int c;
    ring_lits = '{8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0};

    repeat (3) @(negedge clk_i);
    chk("rst_ring", {24'd0, dll_phase}, 32'h0000_00F0);
    chk("rst_outs", {tdc_start, tdc_trigger, tdc_tgate, busy, done, tdc_spaden, pulse_idx}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      chk("ring_step", {24'd0, dll_phase}, {24'd0, ring_lits[i]});
    end

    set_cfg(4, 3, 2, 1, 2, 16'h0001, 1'b0);
    run_seq();
    chk("t1_done_cyc", done_cyc, 32'd17);
    chk("t1_start", n_start, 32'd4);
    chk("t1_trig", n_trig, 32'd6);
    chk("t1_tgate", n_tgate, 32'd4);
    chk("t1_npulse", sp_seen.size(), 32'd2);

    set_cfg(1, 1, 1, 1, 3, 16'h8001, 1'b1);
    run_seq();
    chk("t2_npulse", sp_seen.size(), 32'd3);
    if (sp_seen.size() == 3) begin
      chk("t2_sp0", {16'd0, sp_seen[0]}, 32'h8001);
      chk("t2_sp1", {16'd0, sp_seen[1]}, 32'h0003);
      chk("t2_sp2", {16'd0, sp_seen[2]}, 32'h0006);
    end

    set_cfg(0, 0, 0, 0, 1, 16'h00F0, 1'b0);
    run_seq();
    chk("t3_done_cyc", done_cyc, 32'd5);
    chk("t3_trig", n_trig, 32'd2);
    chk("t3_tgate", n_tgate, 32'd1);

    set_cfg(3, 2, 2, 2, 0, 16'hFFFF, 1'b1);
    run_seq();
    chk("t4_done_cyc", done_cyc, 32'd4);
    chk("t4_trig", n_trig, 32'd0);

    set_cfg(0, 0, 0, 0, 1, 16'h0000, 1'b1);
    run_seq();
    chk("t5_zero_pat", sp_seen.size(), 32'd1);
    if (sp_seen.size() == 1) chk("t5_sp", {16'd0, sp_seen[0]}, 32'd0);

    // Abort during the second gate.
    set_cfg(2, 2, 3, 1, 3, 16'h0101, 1'b1);
    @(negedge clk_i); en = 1'b1;
    c = 0;
    do begin @(posedge clk_i); #1; c++; end while (!(tdc_tgate && pulse_idx == 8'd1) && c < 100);
    chk("abort_reach", {31'd0, tdc_tgate}, 32'd1);
    @(negedge clk_i); en = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pulse", {tdc_trigger, tdc_tgate, done, tdc_spaden}, 32'd0);
    chk("abort_idx", {24'd0, pulse_idx}, 32'd0);
    repeat (4) begin @(posedge clk_i); #1; chk("abort_nodone", {31'd0, done}, 32'd0); end

    // Asynchronous reset mid-sequence.
    set_cfg(2, 3, 3, 3, 2, 16'h0F0F, 1'b0);
    @(negedge clk_i); en = 1'b1;
    repeat (9) @(negedge clk_i);
    #2 rst = 1'b0;
    #1;
    chk("arst_ring", {24'd0, dll_phase}, 32'h0000_00F0);
    chk("arst_outs", {tdc_start, tdc_trigger, tdc_tgate, busy, tdc_spaden}, 32'd0);
    en = 1'b0;
    @(negedge clk_i); rst = 1'b1;
    @(posedge clk_i); #1;
    chk("arst_ring_step", {24'd0, dll_phase}, 32'h0000_0078);

    // Random traffic with occasional aborts and config churn.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) en = 1'b0;
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 4), NSPAD'($urandom), 1'($urandom));
    end
    @(negedge clk_i); en = 1'b0;
    repeat (5) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=expired expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
